spi_frame_receiver: RTL

Receive-side endpoint of the board-to-board SPI command link. Deserialises frames sent by the SPI master: SS low, 64 data bits LSB first, one even-parity bit, SS high. Checks length and parity, presents the word on a valid/ready port to the instruction decoder, and drives SACK so the master either retires the word or retransmits it after its 100-cycle ACK timeout.

---
 rtl/spi_frame_receiver.sv | 104 ++++++++++
 1 files changed

// File: rtl/spi_frame_receiver.sv
// spi_frame_receiver: deserialises SS-framed LSB-first SPI words with even parity,
// presents them on a valid/ready port and acknowledges accepted frames on SACK.
module spi_frame_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  SS,
    input  logic                  SCLK,
    input  logic                  SD,
    output logic                  SACK,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  VALID,
    input  logic                  READY,
    output logic                  ERR_PARITY,
    output logic                  ERR_LEN,
    output logic                  ERR_OVF,
    output logic [7:0]            ERR_CNT
);
    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
    localparam logic [6:0] DW  = 7'(DATA_WIDTH);
    localparam logic [6:0] LEN = 7'(DATA_WIDTH + 1);
    state_t                  state;
    logic [SYNC_STAGES-1:0]  ss_sync, sclk_sync, sd_sync;
    logic                    sclk_prev, parity, rx_par;
    logic [6:0]              count;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    ss_s, sclk_s, sd_s, sclk_rise, len_ok, good, out_full;
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign sd_s      = sd_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s && !sclk_prev;
    assign len_ok    = count == LEN;
    assign good      = len_ok && (rx_par == parity);
    assign out_full  = VALID && !READY;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            ss_sync    <= '1;
            sclk_sync  <= '0;
            sd_sync    <= '0;
            sclk_prev  <= 1'b0;
            count      <= '0;
            parity     <= 1'b0;
            rx_par     <= 1'b0;
            shift_reg  <= '0;
            SACK       <= 1'b0;
            DATA_OUT   <= '0;
            VALID      <= 1'b0;
            ERR_PARITY <= 1'b0;
            ERR_LEN    <= 1'b0;
            ERR_OVF    <= 1'b0;
            ERR_CNT    <= '0;
        end else begin
            ss_sync    <= {ss_sync[SYNC_STAGES-2:0], SS};
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            sd_sync    <= {sd_sync[SYNC_STAGES-2:0], SD};
            sclk_prev  <= sclk_s;
            ERR_PARITY <= 1'b0;
            ERR_LEN    <= 1'b0;
            ERR_OVF    <= 1'b0;
            if (VALID && READY)
                VALID <= 1'b0;
            case (state)
                IDLE: if (!ss_s) begin
                    count  <= '0;
                    parity <= 1'b0;
                    SACK   <= 1'b0;
                    state  <= RECV;
                end
                RECV: begin
                    // shifting right lands bit 0 at the LSB once all data bits are in
                    if (sclk_rise) begin
                        if (count < DW) begin
                            shift_reg <= {sd_s, shift_reg[DATA_WIDTH-1:1]};
                            parity    <= parity ^ sd_s;
                        end else if (count == DW)
                            rx_par <= sd_s;
                        if (count != 7'd127)
                            count <= count + 7'd1;
                    end
                    if (ss_s)
                        state <= CHECK;
                end
                CHECK: begin
                    state <= IDLE;
                    if (good && !out_full) begin
                        DATA_OUT <= shift_reg;
                        VALID    <= 1'b1;
                        SACK     <= 1'b1;
                    end else begin
                        ERR_OVF    <= good;
                        ERR_PARITY <= len_ok && !good;
                        ERR_LEN    <= !len_ok;
                        if (ERR_CNT != 8'hFF)
                            ERR_CNT <= ERR_CNT + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
